// File: rtl/mux4_pkg.sv
// Shared encodings and defaults for the registered 4:1 multiplexer.
// Users of mux4_registered may enable the parity output with MUX4_REGISTERED_PARITY_EN.
package mux4_pkg;

  localparam logic [1:0] SEL_IN1 = 2'b00;
  localparam logic [1:0] SEL_IN2 = 2'b01;
  localparam logic [1:0] SEL_IN3 = 2'b10;
  localparam logic [1:0] SEL_IN4 = 2'b11;

  localparam int MUX4_DEFAULT_WIDTH = 8;

endpackage : mux4_pkg

// File: rtl/mux4_comb.sv
// Combinational 4:1 selector.
// An undecodable sel (X/Z in simulation) yields all-zeros rather than propagating X.
module mux4_comb
  import mux4_pkg::*;
#(
  parameter int WIDTH = MUX4_DEFAULT_WIDTH
) (
  input  logic [1:0]       sel,
  input  logic [WIDTH-1:0] in1,
  input  logic [WIDTH-1:0] in2,
  input  logic [WIDTH-1:0] in3,
  input  logic [WIDTH-1:0] in4,
  output logic [WIDTH-1:0] y
);

  always_comb begin
    y = '0;
    case (sel)
      SEL_IN1: y = in1;
      SEL_IN2: y = in2;
      SEL_IN3: y = in3;
      SEL_IN4: y = in4;
      default: y = '0;
    endcase
  end

endmodule : mux4_comb

// File: rtl/mux4_registered.sv
// 4:1 multiplexer with a registered output and asynchronous active-high reset.
// Define MUX4_REGISTERED_PARITY_EN to add out_par, the registered XOR-reduction of the selection.
module mux4_registered
  import mux4_pkg::*;
#(
  parameter int WIDTH = MUX4_DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [1:0]       sel,
  input  logic [WIDTH-1:0] in1,
  input  logic [WIDTH-1:0] in2,
  input  logic [WIDTH-1:0] in3,
  input  logic [WIDTH-1:0] in4,
  output logic [WIDTH-1:0] out
`ifdef MUX4_REGISTERED_PARITY_EN
  ,
  output logic             out_par
`endif
);

  logic [WIDTH-1:0] y_p0;

  mux4_comb #(
    .WIDTH(WIDTH)
  ) u_comb (
    .sel(sel),
    .in1(in1),
    .in2(in2),
    .in3(in3),
    .in4(in4),
    .y  (y_p0)
  );

  // p0 -> p1: output register; reset clears it without waiting for a clock edge
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out <= '0;
    end else begin
      out <= y_p0;
    end
  end

`ifdef MUX4_REGISTERED_PARITY_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_par <= 1'b0;
    end else begin
      out_par <= ^y_p0;
    end
  end
`endif

endmodule : mux4_registered

// File: tb/tb_mux4_registered.sv
// Scoreboard bench for mux4_registered: 8-bit and 16-bit instances, directed and random stimulus.
// Build with MUX4_REGISTERED_PARITY_EN defined to also check out_par.
module tb_mux4_registered;

  typedef struct {
    int          due;
    logic [7:0]  e8;
    logic [15:0] e16;
    logic        p8;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  sel;
  logic [7:0]  in1, in2, in3, in4;
  logic [15:0] w1, w2, w3, w4;
  logic [7:0]  out;
  logic [15:0] out16;
`ifdef MUX4_REGISTERED_PARITY_EN
  logic        out_par;
`endif

  exp_t q[$];
  int   cyc   = 0;
  int   total = 0;
  int   bad   = 0;

  mux4_registered dut8 (
    .clk(clk), .rst(rst), .sel(sel),
    .in1(in1), .in2(in2), .in3(in3), .in4(in4),
    .out(out)
`ifdef MUX4_REGISTERED_PARITY_EN
    , .out_par(out_par)
`endif
  );

  mux4_registered #(16) dut16 (
    .clk(clk), .rst(rst), .sel(sel),
    .in1(w1), .in2(w2), .in3(w3), .in4(w4),
    .out(out16)
`ifdef MUX4_REGISTERED_PARITY_EN
    , .out_par()
`endif
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference model: index the sources by sel, parity = odd count of ones.
  task automatic push_exp();
    exp_t        e;
    logic [7:0]  v8[4];
    logic [15:0] v16[4];
    v8  = '{in1, in2, in3, in4};
    v16 = '{w1, w2, w3, w4};
    e.due = cyc + 1;
    e.e8  = v8[sel];
    e.e16 = v16[sel];
    e.p8  = ($countones(v8[sel]) % 2) == 1;
    q.push_back(e);
  endtask

  // Monitor: compare every expectation that matured at the last rising edge.
  always @(negedge clk) begin
    while (q.size() > 0 && q[0].due <= cyc) begin
      exp_t e;
      e = q.pop_front();
      if (e.due < cyc) begin
        total++;
        bad++;
        $display("FAIL late: expectation due at %0d still queued at %0d", e.due, cyc);
      end else begin
        check("out8", 32'(out), 32'(e.e8));
        check("out16", 32'(out16), 32'(e.e16));
`ifdef MUX4_REGISTERED_PARITY_EN
        check("out_par", 32'(out_par), 32'(e.p8));
`endif
      end
    end
  end

  task automatic reset_checks(input string tag);
    check({tag, "_out8"}, 32'(out), 32'h0);
    check({tag, "_out16"}, 32'(out16), 32'h0);
`ifdef MUX4_REGISTERED_PARITY_EN
    check({tag, "_par"}, 32'(out_par), 32'h0);
`endif
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    sel = 2'b00;
    in1 = 8'hF5; in2 = 8'h15; in3 = 8'h3B; in4 = 8'h73;
    w1 = 16'h1234; w2 = 16'h5678; w3 = 16'hA5A5; w4 = 16'hFFFF;
    #1;
    reset_checks("rst_pre_edge");
    next_cycle();
    reset_checks("rst_held_edge");

    // Release and walk all four sel codes
    rst = 1'b0;
    push_exp();
    for (int s = 1; s < 4; s++) begin
      next_cycle();
      sel = 2'(s);
      push_exp();
    end

    // Between-edge sel changes must not reach out early
    next_cycle();
    sel = 2'b01;
    push_exp();
    next_cycle();
    sel = 2'b00;
    #2 check("hold_mid_a", 32'(out), 32'h15);
    sel = 2'b11;
    #2 check("hold_mid_b", 32'(out), 32'h15);
    push_exp();
    next_cycle();
    check("after_edge", 32'(out), 32'h73);

    // Asynchronous reset between edges overrides the in-flight selection
    sel = 2'b10;
    push_exp();
    #2;
    rst = 1'b1;
    q.delete();
    #1;
    reset_checks("rst_async");
    sel = 2'b01;
    next_cycle();
    reset_checks("rst_async_edge");
    rst = 1'b0;
    push_exp();
    next_cycle();
    check("post_rst_out8", 32'(out), 32'h15);

    // 16-bit instance with in3=A5A5
    sel = 2'b10;
    w3  = 16'hA5A5;
    push_exp();

    // Random traffic, all inputs changing every cycle
    for (int i = 0; i < 300; i++) begin
      next_cycle();
      sel = 2'($urandom_range(0, 3));
      in1 = 8'($urandom); in2 = 8'($urandom); in3 = 8'($urandom); in4 = 8'($urandom);
      w1 = 16'($urandom); w2 = 16'($urandom); w3 = 16'($urandom); w4 = 16'($urandom);
      push_exp();
    end

    repeat (3) @(posedge clk);
    #1;
    total++;
    if (q.size() != 0) begin
      bad++;
      $display("FAIL drain: got %0d pending want 0", q.size());
    end

    rst = 1'b1;
    #1;
    reset_checks("final_rst");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_mux4_registered

// File: doc/mux4_registered.md
MUX4_REGISTERED -- requirements
Module: mux4_registered

Interface
REQ-001 The module SHALL have parameter WIDTH, default 8, giving the data width of every data input and the output; it SHALL be the first and only positional parameter.
REQ-002 Port clk SHALL be an input, 1 bit wide, and be the single clock; all state updates on its rising edge.
REQ-003 Port rst SHALL be an input, 1 bit wide, and be the asynchronous, active-high reset.
REQ-004 Port sel SHALL be an input, 2 bits wide, and select the source data input.
REQ-005 Ports in1, in2, in3 and in4 SHALL each be an input of WIDTH bits and be data sources 0..3.
REQ-006 Port out SHALL be an output of WIDTH bits, driven directly from a register.
REQ-007 Ports SHALL be connectable by name as clk, rst, sel, in1, in2, in3, in4, out; with the macro undefined, no other ports SHALL exist.

Function
REQ-008 Selection SHALL be: sel=00 -> in1, 01 -> in2, 10 -> in3, 11 -> in4.
REQ-009 On each rising clk edge with rst low, out SHALL load the input chosen by the sel and in1..in4 values sampled at that edge.
REQ-010 Latency SHALL be exactly one clock from sel/data to out; changes between edges SHALL NOT affect out.
REQ-011 All four sel codes SHALL be decoded explicitly; no X SHALL propagate for any defined sel.
REQ-012 If sel contains X/Z, out SHALL load all-zeros.
REQ-013 out SHALL be the full WIDTH-bit value with no truncation or extension, for any WIDTH >= 1.
REQ-014 sel and the data inputs MAY change every cycle; each edge SHALL be evaluated independently.

Reset
REQ-015 While rst is high, out SHALL be all-zeros immediately, without waiting for a clk edge.
REQ-016 Asserting rst mid-operation SHALL clear out asynchronously, overriding any in-flight selection.
REQ-017 On the first rising edge after rst deasserts, out SHALL load the selected input per REQ-009.
REQ-018 No other state SHALL exist beyond out and, when enabled, the parity register.

Configuration
REQ-019 Macro MUX4_REGISTERED_PARITY_EN SHALL, when defined, add output port out_par (1 bit): a register loaded on the same edge as out with the XOR-reduction of the selected input, cleared to 0 by rst.
REQ-020 With MUX4_REGISTERED_PARITY_EN undefined, out_par and its logic SHALL be absent, and the port list SHALL be exactly REQ-002..REQ-006.

Structure
REQ-021 A shared package mux4_pkg SHALL hold the sel encoding constants (SEL_IN1=2'b00, SEL_IN2=2'b01, SEL_IN3=2'b10, SEL_IN4=2'b11) and the default width constant (8).
REQ-022 The combinational 4:1 selection SHALL be a sub-module mux4_comb (parameter WIDTH; inputs sel, in1..in4; output y); mux4_registered SHALL wrap it with the output register(s).

Verification
REQ-023 Use in1=F5, in2=15, in3=3B, in4=73. Hold rst=1 with sel=00 for one cycle -> out=00 immediately, including before the first edge.
REQ-024 Release rst with sel=00 -> out=F5 after the next rising edge; sel=01 -> 15; sel=10 -> 3B; sel=11 -> 73, each one edge after sel changes.
REQ-025 Change sel from 00 to 11 between edges -> out stays at the previous value until the next rising edge, then becomes 73.
REQ-026 With out=73, assert rst between edges -> out=00 without a clk edge; after release with sel=01 -> out=15 on the next edge.
REQ-027 With MUX4_REGISTERED_PARITY_EN defined: sel=00 -> out_par=0 (F5 has six ones); sel=11 -> out_par=1 (73 has five ones); rst -> out_par=0.
REQ-028 Instantiate with WIDTH=16: in3=A5A5, sel=10 -> out=A5A5 after one edge, and reset yields 0000.
